instr_ingress_fifo: RTL
=======================

// Module: instr_ingress_fifo
// PURPOSE
//  Single-clock, parametrised command ingress for the video processor. It replaces the fixed pair of
//  32-bit dataA/dataB FIFOs and the separate write-pulse generator with one unit.
//  - A host write strobe (level from the HPS PIO) is edge-detected into exactly one push.
//  - Each push carries NUM_CH words of DATA_W bits, stored atomically as one entry.
//  - Entries are presented first-word-fall-through with a valid/ready handshake.
//  - Outputs: level, almost-full and a sticky overflow flag for host flow control.
// PARAMETERS
//  DATA_W     32   width of one channel word
//  NUM_CH     2    words per entry (2 = dataA,dataB)
//  DEPTH      16   entries; power of two, >=2
//  AF_THRESH  12   almost_full asserted when level >= AF_THRESH (1..DEPTH)
// PORTS
//  clk            in   1                 sole clock; all state on rising edge
//  reset          in   1                 asynchronous, active-high; clears all state
//  wr_strobe      in   1                 host write request level; 0->1 edge = one push
//  data_in        in   NUM_CH*DATA_W     entry payload, channel 0 in LSBs; sampled on edge cycle
//  clr_overflow   in   1                 synchronous clear of overflow
//  rd_ready       in   1                 consumer accepts head entry
//  out_valid      out  1                 head entry present (= !empty)
//  data_out       out  NUM_CH*DATA_W     head entry, valid when out_valid
//  full           out  1                 level == DEPTH
//  almost_full    out  1                 level >= AF_THRESH
//  empty          out  1                 level == 0
//  level          out  $clog2(DEPTH+1)   entries stored
//  overflow       out  1                 sticky: a push was dropped
// BEHAVIOUR
//  Reset values:
//  - Pointers and level = 0; empty = 1; out_valid, full, almost_full, overflow = 0.
//  - data_out = 0.
//  - strobe_q = 1, so a strobe already high at reset release does NOT push.
//  Edge detect:
//  - push_req = wr_strobe & ~strobe_q; strobe_q <= wr_strobe every cycle.
//  - A strobe held high produces one push only.
//  Push:
//  - Accepted when push_req & (~full | pop).
//  - mem[wr_ptr] <= data_in; wr_ptr++ (wraps at DEPTH).
//  Pop:
//  - pop = out_valid & rd_ready; rd_ptr++ (wraps at DEPTH).
//  - data_out = mem[rd_ptr] (register read, no extra latency).
//  Latency:
//  - Push in cycle k -> level/out_valid updated in cycle k+1.
//  - Entry visible on data_out from cycle k+1 if the FIFO was empty.
//  Level:
//  - +1 on push only; -1 on pop only; unchanged on simultaneous push+pop.
//  Boundary conditions:
//  - full & push_req & ~pop: entry dropped, state unchanged, overflow <= 1.
//  - full & push_req & pop: both performed, level stays DEPTH, no overflow.
//  - empty & rd_ready: no pop, pointers unchanged.
//  - Push into empty with rd_ready high: not popped the same cycle (no bypass).
//  - clr_overflow and a drop in the same cycle: set wins, overflow = 1.
//  - Reset mid-operation: all contents discarded immediately (async); mem contents
//    need not be cleared.
//  Flags full/almost_full/empty are derived from level; level is registered, flags
//  combinational from it.
// STRUCTURE
//  Package colenda_pkg:
//  - COLENDA_DATA_W = 32, COLENDA_NUM_CH = 2, COLENDA_FIFO_DEPTH = 16.
//  - Entry typedef: packed array [NUM_CH][DATA_W].
//  Sub-module rise_pulse (clk, reset, in, pulse):
//  - Rising-edge detector with reset value 1 on the history flop.
//  - Replaces written_pulse across the design.
//  Storage: register array (DEPTH x NUM_CH*DATA_W); pointers $clog2(DEPTH) bits;
//  elaboration-time check that DEPTH is a power of two.
// TESTING
//  1. Reset with wr_strobe=1, release, hold strobe 5 cycles
//     -> level stays 0, empty=1; drop strobe, raise once -> level=1.
//  2. Push 0x11/0x22 then 0x33/0x44 with rd_ready=0
//     -> out_valid at k+1, data_out = {0x22,0x11}; level=2.
//     Pop twice -> {0x44,0x33}, then empty=1.
//  3. 16 pushes with rd_ready=0
//     -> almost_full from level 12, full at 16.
//     17th push -> level=16, overflow=1, head unchanged.
//     clr_overflow -> overflow=0.
//  4. Full FIFO: push 0xAA/0xBB with rd_ready=1 the same cycle
//     -> level stays 16, overflow=0, new entry is last out.
//  5. Drop and clr_overflow in the same cycle -> overflow=1.
//     Later, reset asserted mid-stream (async, between edges)
//     -> level=0, out_valid=0 before the next clock edge.
//  6. 40 random push/pop cycles against a scoreboard queue
//     -> data order and level match, pointers wrap without loss.

Source files
------------

// File: rtl/colenda_pkg.sv
// Shared constants and types for the video-processor command path.
// Holds the default geometry of the ingress FIFO, the entry type and a
// helper used by elaboration-time parameter checks.
package colenda_pkg;

    localparam int unsigned COLENDA_DATA_W     = 32;
    localparam int unsigned COLENDA_NUM_CH     = 2;
    localparam int unsigned COLENDA_FIFO_DEPTH = 16;
    localparam int unsigned COLENDA_AF_THRESH  = 12;

    // One command entry: channel 0 (dataA) in the LSBs, channel 1 (dataB) above.
    typedef logic [COLENDA_NUM_CH-1:0][COLENDA_DATA_W-1:0] colenda_entry_t;

    function automatic bit colenda_is_pow2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/rise_pulse.sv
// Rising-edge detector: one-cycle pulse on every 0->1 transition of 'in'.
// The history flop resets to 1, so an input already high when reset is
// released is not mistaken for a new edge.
// Ports:
//   clk    in  sole clock
//   reset  in  asynchronous, active-high
//   in     in  level to watch
//   pulse  out high for one cycle after a rising edge of 'in'
module rise_pulse (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in;
        end
    end

    always_comb begin
        pulse = in & ~in_q;
    end

endmodule

// File: rtl/instr_ingress_fifo.sv
// Command ingress FIFO for the video processor. A host write strobe is
// edge-detected into a single push of NUM_CH words stored as one entry;
// entries are presented first-word-fall-through with a valid/ready handshake.
// Ports:
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous, active-high; clears all state
//   wr_strobe     in   host write level; 0->1 edge = one push
//   data_in       in   entry payload, channel 0 in LSBs
//   clr_overflow  in   synchronous clear of overflow
//   rd_ready      in   consumer accepts the head entry
//   out_valid     out  head entry present
//   data_out      out  head entry (0 while empty)
//   full          out  level == DEPTH
//   almost_full   out  level >= AF_THRESH
//   empty         out  level == 0
//   level         out  number of stored entries
//   overflow      out  sticky: a push was dropped
module instr_ingress_fifo
    import colenda_pkg::*;
#(
    parameter int unsigned DATA_W    = COLENDA_DATA_W,
    parameter int unsigned NUM_CH    = COLENDA_NUM_CH,
    parameter int unsigned DEPTH     = COLENDA_FIFO_DEPTH,
    parameter int unsigned AF_THRESH = COLENDA_AF_THRESH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_strobe,
    input  logic [NUM_CH*DATA_W-1:0]     data_in,
    input  logic                         clr_overflow,
    input  logic                         rd_ready,
    output logic                         out_valid,
    output logic [NUM_CH*DATA_W-1:0]     data_out,
    output logic                         full,
    output logic                         almost_full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    typedef logic [NUM_CH-1:0][DATA_W-1:0] entry_t;

    if (!colenda_is_pow2(DEPTH)) begin : g_depth_chk
        $error("instr_ingress_fifo: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_chk
        $error("instr_ingress_fifo: AF_THRESH must lie in 1..DEPTH");
    end

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               drop;

    rise_pulse u_strobe_edge (
        .clk   (clk),
        .reset (reset),
        .in    (wr_strobe),
        .pulse (push_req)
    );

    // Flags are pure decodes of the registered level.
    always_comb begin
        empty       = (level == '0);
        full        = (level == LVL_W'(DEPTH));
        almost_full = (level >= LVL_W'(AF_THRESH));
        out_valid   = ~empty;
        data_out    = out_valid ? mem[rd_ptr] : '0;
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is only dropped when the consumer is not draining.
    always_comb begin
        pop  = out_valid & rd_ready;
        push = push_req & (~full | pop);
        drop = push_req & full & ~pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage carries no reset; stale slots are never visible because
    // data_out is gated by out_valid and only written slots are read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_t'(data_in);
        end
    end

endmodule
